// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM (fetch/decode/mem/exec/branch)
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regwrite,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic       pcsource,
    output logic       retire,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ILLEGAL = 4'd9
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_REGA  = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;
    localparam logic [1:0] SRCB_REGB  = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regwrite    = 1'b0;
        alusrca     = SRCA_PC;
        alusrcb     = SRCB_REGB;
        aluop       = ALU_ADD;
        pcsource    = 1'b0;
        retire      = 1'b0;

        case (state_q)
            S_FETCH: begin
                memread = 1'b1;
                alusrca = SRCA_PC;
                alusrcb = SRCB_FOUR;
                aluop   = ALU_ADD;
                // IR and PC+4 are committed in the same cycle the read completes
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                aluop   = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
                        state_d   = S_ILLEGAL;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_IMM;
                aluop   = ALU_ADD;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                alusrca = SRCA_REGA;
                alusrcb = SRCB_REGB;
                aluop   = ALU_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b0;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                alusrca     = SRCA_REGA;
                alusrcb     = SRCB_REGB;
                aluop       = ALU_SUB;
                pcwritecond = 1'b1;
                pcsource    = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_ILLEGAL: begin
                state_d   = S_ILLEGAL;
                illegal_d = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every side-effecting strobe; operand selects are harmless
        if (rst) begin
            pcwrite     = 1'b0;
            pcwritecond = 1'b0;
            memread     = 1'b0;
            memwrite    = 1'b0;
            irwrite     = 1'b0;
            regwrite    = 1'b0;
            retire      = 1'b0;
        end
    end

    assign illegal = illegal_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regwrite, pcsource, retire, illegal;
    logic [1:0] alusrca, alusrcb, aluop;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4;
    localparam int MEMWR = 5, EXEC = 6, ALUWB = 7, BRANCH = 8, ILLEGAL = 9;
    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011, OP_BEQ = 7'b1100011;

    typedef struct {
        int   st;
        logic mr;
    } cyc_t;

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .pcsource(pcsource),
        .retire(retire), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs straight from the per-state output table
    function automatic logic [16:0] exp_out(input int st, input logic mr, input logic r);
        logic pcw, pcc, io, mrd, mwr, irw, m2r, rw, pcs, ret, ill;
        logic [1:0] a, b, op;
        {pcw, pcc, io, mrd, mwr, irw, m2r, rw, pcs, ret, ill} = '0;
        a = 2'b00; b = 2'b00; op = 2'b00;
        case (st)
            FETCH:   begin mrd = 1; b = 2'b01; irw = mr; pcw = mr; end
            DECODE:  begin a = 2'b10; b = 2'b10; end
            MEMADR:  begin a = 2'b01; b = 2'b10; end
            MEMRD:   begin io = 1; mrd = 1; end
            MEMWB:   begin rw = 1; m2r = 1; ret = 1; end
            MEMWR:   begin io = 1; mwr = 1; ret = mr; end
            EXEC:    begin a = 2'b01; op = 2'b10; end
            ALUWB:   begin rw = 1; ret = 1; end
            BRANCH:  begin a = 2'b01; op = 2'b01; pcc = 1; pcs = 1; ret = 1; end
            ILLEGAL: begin ill = 1; end
            default: ;
        endcase
        if (r) {pcw, pcc, mrd, mwr, irw, rw, ret} = '0;
        return {pcw, pcc, io, mrd, mwr, irw, m2r, rw, a, b, op, pcs, ret, ill};
    endfunction

    task automatic step(input logic [6:0] op, input logic mr, input logic r, input int es);
        logic [16:0] obs;
        opcode = op; mem_ready = mr; rst = r;
        #3;
        obs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regwrite,
               alusrca, alusrcb, aluop, pcsource, retire, illegal};
        check("state", 32'(state), 32'(es));
        check("outputs", 32'(obs), 32'(exp_out(es, mr, r)));
        check("mem_rw_excl", 32'(memread & memwrite), 32'd0);
        check("write_excl", 32'($countones({regwrite, pcwrite, pcwritecond, memwrite}) <= 1), 32'd1);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] rand_illegal_op();
        logic [6:0] o;
        do o = 7'($urandom); while (o == OP_LW || o == OP_SW || o == OP_R || o == OP_BEQ);
        return o;
    endfunction

    // Builds the cycle-by-cycle state trace of one instruction from the sequencing rules
    task automatic run_instr(input int kind);
        cyc_t q[$];
        logic [6:0] op;
        int n;
        case (kind)
            0: op = OP_R;
            1: op = OP_LW;
            2: op = OP_SW;
            default: op = OP_BEQ;
        endcase
        n = $urandom_range(0, 5);
        repeat (n) q.push_back('{FETCH, 1'b0});
        q.push_back('{FETCH, 1'b1});
        q.push_back('{DECODE, 1'($urandom)});
        case (kind)
            0: begin
                q.push_back('{EXEC, 1'($urandom)});
                q.push_back('{ALUWB, 1'($urandom)});
            end
            1: begin
                q.push_back('{MEMADR, 1'($urandom)});
                n = $urandom_range(0, 4);
                repeat (n) q.push_back('{MEMRD, 1'b0});
                q.push_back('{MEMRD, 1'b1});
                q.push_back('{MEMWB, 1'($urandom)});
            end
            2: begin
                q.push_back('{MEMADR, 1'($urandom)});
                n = $urandom_range(0, 4);
                repeat (n) q.push_back('{MEMWR, 1'b0});
                q.push_back('{MEMWR, 1'b1});
            end
            default: q.push_back('{BRANCH, 1'($urandom)});
        endcase
        foreach (q[i]) begin
            step((q[i].st == FETCH) ? 7'($urandom) : op, q[i].mr, 1'b0, q[i].st);
        end
    endtask

    initial begin
        logic [6:0] bad;
        rst = 1'b1; opcode = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        step(7'd0, 1'b1, 1'b1, FETCH);

        // lw with three MEMRD wait cycles, everything else single-cycle
        step(7'd0, 1'b1, 1'b0, FETCH);
        step(OP_LW, 1'b0, 1'b0, DECODE);
        step(OP_LW, 1'b0, 1'b0, MEMADR);
        repeat (3) step(OP_LW, 1'b0, 1'b0, MEMRD);
        step(OP_LW, 1'b1, 1'b0, MEMRD);
        step(OP_LW, 1'b0, 1'b0, MEMWB);

        for (int i = 0; i < 60; i++) run_instr($urandom_range(0, 3));

        // reset in the middle of a stalled store
        step(7'd0, 1'b1, 1'b0, FETCH);
        step(OP_SW, 1'b1, 1'b0, DECODE);
        step(OP_SW, 1'b1, 1'b0, MEMADR);
        step(OP_SW, 1'b0, 1'b0, MEMWR);
        step(OP_SW, 1'b0, 1'b1, MEMWR);
        step(OP_SW, 1'b0, 1'b0, FETCH);
        step(OP_SW, 1'b1, 1'b0, FETCH);
        step(OP_R, 1'b1, 1'b0, DECODE);
        step(OP_R, 1'b1, 1'b0, EXEC);
        step(OP_R, 1'b1, 1'b0, ALUWB);

        // unsupported opcodes lock up until reset
        for (int k = 0; k < 3; k++) begin
            bad = (k == 0) ? 7'b1111111 : rand_illegal_op();
            step(7'($urandom), 1'b1, 1'b0, FETCH);
            step(bad, 1'($urandom), 1'b0, DECODE);
            repeat (12) step(7'($urandom), 1'($urandom), 1'b0, ILLEGAL);
            step(7'($urandom), 1'($urandom), 1'b1, ILLEGAL);
            step(7'($urandom), 1'b0, 1'b0, FETCH);
            run_instr($urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
